// File: rtl/function_generator_sequencer_if.sv
// Sample RAM port shared between the waveform sequencer (master) and the RAM (slave).
// ram_rdata is valid the cycle after a read access (ram_en=1, ram_we=0).
interface function_generator_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (output ram_en, ram_we, ram_addr, ram_wdata, input ram_rdata);
    modport slave  (input ram_en, ram_we, ram_addr, ram_wdata, output ram_rdata);
endinterface

// File: rtl/function_generator_sequencer.sv
// Waveform player: fetches samples from the shared RAM port and presents them on dac
// every max(DIV,2) clocks, looping or one-shot over the [START, END] address window.
module function_generator_sequencer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [DIV_W-1:0]     cfg_wdata,
    input  logic                 host_req,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_gnt,
    function_generator_sequencer_if.master ram,
    output logic [DATA_W-1:0]    dac,
    output logic                 sample_strobe,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    cur_addr,
    output logic [1:0]           fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

    state_t            state, state_nx;
    logic [1:0]        ctrl;
    logic [ADDR_W-1:0] start_addr, end_addr, ptr, next_ptr;
    logic [DIV_W-1:0]  div, div_eff, cnt;
    logic              last_q;
    logic              ctrl_wr, start_cmd, stop_cmd;
    logic              prefetch_slot, one_shot_end, seq_rd;
    logic              dac_load, finish;

    assign ctrl_wr   = cfg_we && (cfg_addr == 2'd0);
    assign start_cmd = ctrl_wr && cfg_wdata[0];
    assign stop_cmd  = ctrl_wr && !cfg_wdata[0];
    assign div_eff   = (div < DIV_W'(2)) ? DIV_W'(2) : div;

    // Pointer decision uses the live START/END/loop values at the prefetch cycle.
    assign next_ptr      = ((ptr == end_addr) && ctrl[1]) ? start_addr : ptr + ADDR_W'(1);
    assign prefetch_slot = (state == HOLD) && (cnt == DIV_W'(2));
    assign one_shot_end  = prefetch_slot && (ptr == end_addr) && !ctrl[1];
    assign seq_rd        = (state == FETCH) || (prefetch_slot && !one_shot_end);

    // Host handshake: host_req is the valid, host_gnt the same-cycle ready; the write
    // lands at the clock edge where both are high. Sequencer reads always win the port.
    assign host_gnt      = resetb && host_req && !seq_rd;
    assign ram.ram_en    = seq_rd || host_gnt;
    assign ram.ram_we    = host_gnt;
    assign ram.ram_addr  = !seq_rd ? host_addr : ((state == FETCH) ? ptr : next_ptr);
    assign ram.ram_wdata = host_wdata;

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        dac_load = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE:  state_nx = IDLE;
            FETCH: state_nx = WAIT;
            WAIT: begin
                state_nx = HOLD;
                dac_load = 1'b1;
            end
            HOLD: begin
                if (cnt == DIV_W'(1)) begin
                    if (last_q) begin
                        state_nx = IDLE;
                        finish   = 1'b1;
                    end else begin
                        dac_load = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // A CTRL write overrides everything, discarding any in-flight fetch.
        if (start_cmd || stop_cmd) begin
            state_nx = start_cmd ? FETCH : IDLE;
            dac_load = 1'b0;
            finish   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ctrl          <= '0;
            start_addr    <= '0;
            end_addr      <= '0;
            div           <= DIV_W'(2);
            ptr           <= '0;
            cnt           <= '0;
            last_q        <= 1'b0;
            dac           <= '0;
            cur_addr      <= '0;
            done          <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= dac_load;
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    ctrl       <= cfg_wdata[1:0];
                    2'd1:    start_addr <= cfg_wdata[ADDR_W-1:0];
                    2'd2:    end_addr   <= cfg_wdata[ADDR_W-1:0];
                    default: div        <= cfg_wdata;
                endcase
            end
            if (finish) begin
                ctrl[0] <= 1'b0;
                done    <= 1'b1;
            end
            if (start_cmd) begin
                ptr    <= start_addr;
                done   <= 1'b0;
                last_q <= 1'b0;
            end else if (prefetch_slot) begin
                last_q <= one_shot_end;
                if (!one_shot_end) ptr <= next_ptr;
            end
            if (dac_load) begin
                dac      <= ram.ram_rdata;
                cur_addr <= ptr;
                cnt      <= div_eff;
            end else if (state == HOLD) begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_function_generator_sequencer.sv
// Scoreboarded bench for function_generator_sequencer: expected dac updates (time, address,
// sample) come from a list-level playback model and are checked on every sample_strobe.
module tb_function_generator_sequencer;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int W      = 32 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              resetb = 1'b1;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_addr = '0;
    logic [DIV_W-1:0]  cfg_wdata = '0;
    logic              host_req = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_gnt;
    logic [DATA_W-1:0] dac;
    logic              sample_strobe, busy, done;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        fsm_state;

    function_generator_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

    function_generator_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .resetb(resetb),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .ram(ram_bus),
        .dac(dac), .sample_strobe(sample_strobe), .busy(busy), .done(done),
        .cur_addr(cur_addr), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset, RAM model ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] ram_mem [512];
    logic [DATA_W-1:0] ref_mem [512];

    always @(posedge clk) begin
        if (ram_bus.ram_en) begin
            if (ram_bus.ram_we) ram_mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
            else                ram_bus.ram_rdata <= ram_mem[ram_bus.ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (resetb) begin
            if (sample_strobe) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", int'(dac), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("update_cycle", cyc, int'(mon_e[W-1 -: 32]));
                    check("dac", int'(dac), int'(mon_e[DATA_W-1:0]));
                    check("cur_addr", int'(cur_addr), int'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
                end
            end else if (exp_q.size() > 0 && cyc >= int'(exp_q[0][W-1 -: 32])) begin
                mon_e = exp_q.pop_front();
                check("missed_update", cyc, int'(mon_e[W-1 -: 32]) - 1);
            end
        end
    end

    // Reference playback: walk the address window from the run edge t0.
    task automatic expect_run(input int t0, s, e, dv, input bit lp, input int n,
                              output int t_last, a_last, t_done);
        int a = s;
        int t = t0 + 2;
        int deff = (dv < 2) ? 2 : dv;
        t_done = -1;
        t_last = t;
        a_last = a;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({32'(t), ADDR_W'(a), ref_mem[a]});
            t_last = t;
            a_last = a;
            if (a == e && !lp) begin
                t_done = t + deff;
                break;
            end
            a = (a == e) ? s : (a + 1) % 512;
            t += deff;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cfg_drive(input logic [1:0] a, input int d, output int t);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = DIV_W'(d);
        @(posedge clk); #1;
        t = cyc;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input int d, output int t);
        @(negedge clk);
        cfg_drive(a, d, t);
    endtask

    task automatic host_write(input int a, input int d, output int waits);
        waits = 0;
        @(negedge clk);
        host_req = 1'b1; host_addr = ADDR_W'(a); host_wdata = DATA_W'(d);
        #1;
        while (!host_gnt && waits < 4) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!host_gnt) check("host_grant", int'(host_gnt), 1);
        else begin
            @(posedge clk);
            ref_mem[a] = DATA_W'(d);
        end
        #1 host_req = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        int g = 0;
        do begin @(negedge clk); g++; end while (cyc < t && g < 5000);
        if (cyc < t) check("wait_timeout", cyc, t);
    endtask

    task automatic stop_at(input int tl);
        int t;
        wait_cyc(tl);
        cfg_drive(2'd0, 0, t);
    endtask

    task automatic set_window(input int s, e, dv);
        int t;
        cfg_write(2'd1, s, t);
        cfg_write(2'd2, e, t);
        cfg_write(2'd3, dv, t);
    endtask

    task automatic run_cmd(input int ctrl_val, output int t0);
        cfg_write(2'd0, ctrl_val, t0);
        check("run_busy", int'(busy), 1);
        check("run_done_clear", int'(done), 0);
    endtask

    task automatic run_loop(input int s, e, dv, n);
        int t0, tl, al, td;
        set_window(s, e, dv);
        run_cmd(3, t0);
        expect_run(t0, s, e, dv, 1'b1, n, tl, al, td);
        stop_at(tl);
        check("stop_idle", int'(busy), 0);
        check("stop_done", int'(done), 0);
        repeat (3) @(negedge clk);
        check("stop_dac_hold", int'(dac), int'(ref_mem[al]));
        check("stop_cur_addr", int'(cur_addr), al);
    endtask

    task automatic run_once(input int s, e, dv);
        int t0, tl, al, td;
        set_window(s, e, dv);
        run_cmd(1, t0);
        expect_run(t0, s, e, dv, 1'b0, 600, tl, al, td);
        wait_cyc(td - 1);
        check("busy_before_end", int'(busy), 1);
        check("done_before_end", int'(done), 0);
        @(negedge clk);
        check("done_set", int'(done), 1);
        check("busy_clear", int'(busy), 0);
        check("end_dac_hold", int'(dac), int'(ref_mem[al]));
        check("end_cur_addr", int'(cur_addr), al);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w, t0, tl, al, td, s, e, len, dv;
        bit lp;

        #2 resetb = 1'b0;
        #1;
        check("rst_dac", int'(dac), 0);
        check("rst_cur_addr", int'(cur_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_strobe", int'(sample_strobe), 0);
        check("rst_gnt", int'(host_gnt), 0);
        check("rst_ram_en", int'(ram_bus.ram_en), 0);
        check("rst_ram_we", int'(ram_bus.ram_we), 0);
        repeat (2) @(negedge clk);
        resetb = 1'b1;

        for (int i = 0; i < 4; i++) host_write(i, 10 * (i + 1), w);
        host_write(7, 55, w);

        run_loop(0, 3, 4, 6);
        run_once(0, 3, 4);
        run_loop(0, 3, 0, 5);
        run_loop(0, 3, 1, 5);
        run_loop(0, 3, 2, 5);

        // restart while busy: playback resumes from START before the old next update
        set_window(0, 3, 4);
        run_cmd(3, t0);
        expect_run(t0, 0, 3, 4, 1'b1, 2, tl, al, td);
        wait_cyc(tl);
        cfg_drive(2'd0, 3, t0);
        check("restart_busy", int'(busy), 1);
        expect_run(t0, 0, 3, 4, 1'b1, 3, tl, al, td);
        stop_at(tl);

        // host traffic during playback
        set_window(0, 3, 3);
        run_cmd(3, t0);
        expect_run(t0, 0, 3, 3, 1'b1, 16, tl, al, td);
        fork
            begin
                int hw;
                for (int i = 0; i < 12; i++) begin
                    host_write(300 + i, int'($urandom_range(0, 255)), hw);
                    check("host_stall", (hw <= 1) ? 0 : hw, 0);
                end
            end
            stop_at(tl);
        join
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) check("host_write_landed", int'(ram_mem[300 + i]), int'(ref_mem[300 + i]));

        // wrap through the top of the address space
        host_write(510, 1, w);
        host_write(511, 2, w);
        host_write(0, 3, w);
        host_write(1, 4, w);
        run_once(510, 1, 3);

        for (int it = 0; it < 6; it++) begin
            s   = int'($urandom_range(0, 511));
            len = int'($urandom_range(0, 5));
            e   = (s + len) % 512;
            dv  = int'($urandom_range(0, 5));
            lp  = 1'($urandom_range(0, 1));
            for (int k = 0; k <= len; k++) host_write((s + k) % 512, int'($urandom_range(0, 255)), w);
            if (lp) run_loop(s, e, dv, len + 4);
            else    run_once(s, e, dv);
        end

        // asynchronous reset mid-HOLD with a pending host request
        set_window(0, 3, 5);
        run_cmd(3, t0);
        expect_run(t0, 0, 3, 5, 1'b1, 1, tl, al, td);
        wait_cyc(tl + 1);
        host_req = 1'b1; host_addr = ADDR_W'(7); host_wdata = DATA_W'(99);
        #2 resetb = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_dac", int'(dac), 0);
        check("mid_rst_cur_addr", int'(cur_addr), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_gnt", int'(host_gnt), 0);
        check("mid_rst_ram_en", int'(ram_bus.ram_en), 0);
        repeat (2) @(negedge clk);
        check("mid_rst_gnt_held", int'(host_gnt), 0);
        host_req = 1'b0;
        resetb = 1'b1;
        check("rst_no_write", int'(ram_mem[7]), 55);

        // register reset values: START=END=0, DIV=2
        run_cmd(3, t0);
        expect_run(t0, 0, 0, 2, 1'b1, 4, tl, al, td);
        stop_at(tl);

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/function_generator_sequencer.md
Name: function_generator_sequencer

Overview:
- Plays a stored waveform out of a shared single-port sample RAM into the 8-bit DAC bus (dac, routed to mprj_io[15:8]) at a programmable sample period.
- Sits between the host register interface, the sample RAM and the DAC pins.
- Arbitrates the RAM port between host sample loads and its own timing-critical sample fetches.
- Supports one-shot and looping playback over a programmable address window.

Parameters:
- ADDR_W, 9, sample RAM address width (512 samples).
- DATA_W, 8, sample and DAC width.
- DIV_W, 16, sample-period divider width.

Ports:
- clk  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- cfg_we  in  1  register write strobe, one write per cycle.
- cfg_addr  in  2  register select: 0 CTRL, 1 START, 2 END, 3 DIV.
- cfg_wdata  in  DIV_W  register write data.
- host_req  in  1  host requests a RAM write.
- host_addr  in  ADDR_W  host write address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  combinational; write performed this cycle.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read.
- dac  out  DATA_W  registered DAC sample.
- sample_strobe  out  1  one-cycle pulse in the cycle after dac updates.
- busy  out  1  playback active.
- done  out  1  sticky; one-shot playback completed.
- cur_addr  out  ADDR_W  address of the sample currently on dac.

Behaviour:
- Reset values:
  - dac, cur_addr, busy, done, sample_strobe, host_gnt, ram_en, ram_we = 0.
  - CTRL = 0, START = 0, END = 0, DIV = 2.
- CTRL bits: bit0 run, bit1 loop.
- DIV_eff = max(DIV, 2). The dac update interval is exactly DIV_eff clocks.
- FSM states:
  - IDLE: busy=0.
  - FETCH: ram read at ptr.
  - WAIT: data returning.
  - HOLD: down-counter cnt running.
- Start:
  - Trigger: CTRL write with run=1, sampled at edge E0, from any state.
  - Effects: ptr <= START, done <= 0, busy <= 1, state FETCH.
  - Sequence: E1 -> WAIT; at E2 dac <= ram_rdata, cur_addr <= ptr, cnt <= DIV_eff, state HOLD.
  - If already busy: playback restarts from START.
- HOLD:
  - cnt decrements each clock.
  - cnt==2: prefetch cycle. Drive ram_en=1, ram_we=0, ram_addr=next. next = START if ptr==END and loop, else ptr+1 modulo 2^ADDR_W. Set ptr <= next.
  - cnt==1: data valid. At that edge dac <= ram_rdata, cur_addr <= ptr, cnt <= DIV_eff.
- One-shot end:
  - Applies when ptr==END and loop=0 at the cnt==2 cycle.
  - No prefetch is issued.
  - At the cnt==1 edge: state IDLE, busy <= 0, done <= 1, CTRL.run <= 0; dac holds the last sample.
- END < START: ptr wraps through 2^ADDR_W-1 to 0 and continues until it equals END.
- START == END: the single sample repeats (loop) or plays once.
- Stop: CTRL write with run=0 goes to IDLE at the next edge. dac and cur_addr hold, done unchanged, any in-flight fetch is discarded.
- Config changes while running:
  - START and END are used at the next pointer decision.
  - DIV is used at the next cnt reload.
- Arbitration:
  - The sequencer read (FETCH state or prefetch cycle) has priority.
  - Otherwise host_gnt = host_req and the RAM performs the write that cycle (ram_en=1, ram_we=1, host address and data).
  - A host request stalls at most 1 cycle per sample period.
  - Host writes are allowed during playback.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); a pending host request is not granted until reset is released.

Test Plan:
- Load RAM[0..3] = 10,20,30,40 via host writes; START=0, END=3, DIV=4, loop=1, run -> dac 10 two clocks after the run write, then 20,30,40,10,20 at exactly 4-clock intervals; one sample_strobe per update.
- Same RAM contents, loop=0 -> dac sequence 10,20,30,40; done=1 and busy=0 four clocks after the 40 update; dac stays 40.
- DIV=0 and DIV=1 -> update interval 2 clocks; DIV=2 -> 2 clocks.
- START=510, END=1, RAM[510,511,0,1] = 1,2,3,4, loop=0 -> dac 1,2,3,4 with wrap; cur_addr 510,511,0,1.
- host_req held continuously during playback with DIV=3 -> host_gnt low only during sequencer fetch cycles; no missed or late dac updates; every write lands in RAM.
- Run=0 write mid-playback -> IDLE next edge, dac holds, done=0. Assert resetb low mid-HOLD -> all outputs 0 immediately; the next run restarts from START.
